// File: rtl/pc_unit.sv
// Fetch-stage PC unit: next-PC select, stall/flush control and delay-slot flag.
// Define FETCH_ADDR_CHECK_EN to enable registered fetch-address (AdEL) detection.
module pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int          IM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        exc_req,
    input  logic [31:0] epc,
    input  logic        d_valid,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] pc,
    output logic        flush_f,
    output logic        d_bd,
    output logic        f_exc,
    output logic [4:0]  f_exccode,
    output logic [1:0]  pc_src
);

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_BR   = 2'd1;
    localparam logic [1:0] SRC_ERET = 2'd2;
    localparam logic [1:0] SRC_EXC  = 2'd3;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_ERET    = 6'b011000;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  src_q, src_d;
    logic        bd_q, bd_d;

    logic [5:0]  op;
    logic [4:0]  rt_f;
    logic [5:0]  fn;

    logic is_j, is_jal, is_jr, is_jalr;
    logic is_beq, is_bne, is_blez, is_bgtz;
    logic is_bltz, is_bgez, is_eret;
    logic is_br, is_jimm, is_jreg, is_cti;

    logic        rs_eq_rt, rs_neg, rs_zero;
    logic        br_taken, redirect;
    logic [31:0] p4, imm_ext, br_tgt, j_tgt, tgt;
    logic        pc_upd;

    assign op   = d_instr[31:26];
    assign rt_f = d_instr[20:16];
    assign fn   = d_instr[5:0];

    // Every decoded kind is gated by d_valid so bubbles never redirect.
    always_comb begin
        is_j    = d_valid && (op == OP_J);
        is_jal  = d_valid && (op == OP_JAL);
        is_beq  = d_valid && (op == OP_BEQ);
        is_bne  = d_valid && (op == OP_BNE);
        is_blez = d_valid && (op == OP_BLEZ);
        is_bgtz = d_valid && (op == OP_BGTZ);
        is_bltz = d_valid && (op == OP_REGIMM)
                  && (rt_f == 5'b00000);
        is_bgez = d_valid && (op == OP_REGIMM)
                  && (rt_f == 5'b00001);
        is_jr   = d_valid && (op == OP_SPECIAL)
                  && (fn == FN_JR);
        is_jalr = d_valid && (op == OP_SPECIAL)
                  && (fn == FN_JALR);
        is_eret = d_valid && (op == OP_COP0)
                  && d_instr[25] && (fn == FN_ERET);
    end

    assign is_br   = is_beq | is_bne | is_blez
                   | is_bgtz | is_bltz | is_bgez;
    assign is_jimm = is_j | is_jal;
    assign is_jreg = is_jr | is_jalr;
    assign is_cti  = is_br | is_jimm | is_jreg;

    assign rs_eq_rt = (rs_val == rt_val);
    assign rs_neg   = rs_val[31];
    assign rs_zero  = (rs_val == 32'd0);

    always_comb begin
        br_taken = 1'b0;
        unique case (1'b1)
            is_beq:  br_taken = rs_eq_rt;
            is_bne:  br_taken = !rs_eq_rt;
            is_blez: br_taken = rs_neg || rs_zero;
            is_bgtz: br_taken = !rs_neg && !rs_zero;
            is_bltz: br_taken = rs_neg;
            is_bgez: br_taken = !rs_neg;
            default: br_taken = 1'b0;
        endcase
    end

    assign redirect = br_taken | is_jimm | is_jreg;

    assign p4      = d_pc + 32'd4;
    assign imm_ext = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
    assign br_tgt  = p4 + imm_ext;
    assign j_tgt   = {p4[31:28], d_instr[25:0], 2'b00};

    always_comb begin
        tgt = br_tgt;
        if (is_jreg)
            tgt = rs_val;
        else if (is_jimm)
            tgt = j_tgt;
    end

    // An exception overrides a stall; everything else waits for it.
    assign pc_upd = exc_req | ~stall;

    always_comb begin
        pc_d  = pc_q;
        src_d = src_q;
        if (exc_req) begin
            pc_d  = EXC_VECTOR;
            src_d = SRC_EXC;
        end else if (!stall) begin
            if (is_eret) begin
                pc_d  = epc;
                src_d = SRC_ERET;
            end else if (redirect) begin
                pc_d  = tgt;
                src_d = SRC_BR;
            end else begin
                pc_d  = pc_q + 32'd4;
                src_d = SRC_SEQ;
            end
        end
    end

    always_comb begin
        bd_d = bd_q;
        if (exc_req)
            bd_d = 1'b0;
        else if (!stall)
            bd_d = is_cti;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            src_q <= SRC_SEQ;
            bd_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            src_q <= src_d;
            bd_q  <= bd_d;
        end
    end

    assign pc      = pc_q;
    assign pc_src  = src_q;
    assign d_bd    = bd_q;
    assign flush_f = exc_req | (is_eret & ~stall);

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [32:0] IM_LIMIT =
        33'(IM_BASE) + 33'(4 * IM_WORDS);

    logic       fexc_q, fexc_d;
    logic [4:0] fcode_q, fcode_d;
    logic       bad_addr;

    // Limit is compared in 33 bits so a region ending at 2^32 still works.
    assign bad_addr = (pc_d[1:0] != 2'b00)
                    || (pc_d < IM_BASE)
                    || ({1'b0, pc_d} >= IM_LIMIT);

    always_comb begin
        fexc_d  = fexc_q;
        fcode_d = fcode_q;
        if (pc_upd) begin
            fexc_d  = bad_addr;
            fcode_d = bad_addr ? 5'd4 : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fexc_q  <= 1'b0;
            fcode_q <= 5'd0;
        end else begin
            fexc_q  <= fexc_d;
            fcode_q <= fcode_d;
        end
    end

    assign f_exc     = fexc_q;
    assign f_exccode = fcode_q;
`else
    logic unused_cfg;
    assign unused_cfg = pc_upd;
    assign f_exc      = 1'b0;
    assign f_exccode  = 5'd0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam int          IM_WORDS   = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, exc_req, d_valid;
    logic [31:0] epc, d_instr, d_pc, rs_val, rt_val;
    logic [31:0] pc;
    logic        flush_f, d_bd, f_exc;
    logic [4:0]  f_exccode;
    logic [1:0]  pc_src;

    always #5 clk = ~clk;

    pc_unit #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR),
        .IM_BASE   (IM_BASE),
        .IM_WORDS  (IM_WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .exc_req  (exc_req),
        .epc      (epc),
        .d_valid  (d_valid),
        .d_instr  (d_instr),
        .d_pc     (d_pc),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .pc       (pc),
        .flush_f  (flush_f),
        .d_bd     (d_bd),
        .f_exc    (f_exc),
        .f_exccode(f_exccode),
        .pc_src   (pc_src)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int K_NONE = 0, K_J = 1, K_JAL = 2, K_BEQ = 3;
    localparam int K_BNE = 4, K_BLEZ = 5, K_BGTZ = 6, K_BLTZ = 7;
    localparam int K_BGEZ = 8, K_JR = 9, K_JALR = 10, K_ERET = 11;

    logic [31:0] m_pc;
    logic [1:0]  m_src;
    logic        m_bd, m_fexc;
    logic [4:0]  m_fcode;

    function automatic int kind_of(logic v, logic [31:0] ins);
        int op, rt, fn;
        if (!v) return K_NONE;
        op = int'(ins[31:26]);
        rt = int'(ins[20:16]);
        fn = int'(ins[5:0]);
        case (op)
            2: return K_J;
            3: return K_JAL;
            4: return K_BEQ;
            5: return K_BNE;
            6: return K_BLEZ;
            7: return K_BGTZ;
            1: return rt == 0 ? K_BLTZ : (rt == 1 ? K_BGEZ : K_NONE);
            0: return fn == 8 ? K_JR : (fn == 9 ? K_JALR : K_NONE);
            16: return (ins[25] && fn == 24) ? K_ERET : K_NONE;
            default: return K_NONE;
        endcase
    endfunction

    function automatic bit addr_bad(logic [31:0] a);
        longint ua = longint'(a);
        longint lo = longint'(IM_BASE);
        longint hi = lo + 4 * IM_WORDS;
        return (ua % 4 != 0) || (ua < lo) || (ua >= hi);
    endfunction

    function automatic bit exp_flush();
        return exc_req || (kind_of(d_valid, d_instr) == K_ERET && !stall);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_src = 0; m_bd = 0; m_fexc = 0; m_fcode = 0;
    endtask

    task automatic model_fexc();
`ifdef FETCH_ADDR_CHECK_EN
        m_fexc  = addr_bad(m_pc);
        m_fcode = m_fexc ? 5'd4 : 5'd0;
`else
        m_fexc  = 0;
        m_fcode = 0;
`endif
    endtask

    task automatic model_edge();
        int k = kind_of(d_valid, d_instr);
        logic [31:0] p4 = d_pc + 32'd4;
        logic [31:0] off = {{16{d_instr[15]}}, d_instr[15:0]} << 2;
        int srs = $signed(rs_val);
        bit jump = k inside {K_J, K_JAL, K_JR, K_JALR};
        bit taken = 0;
        logic [31:0] tgt = p4 + off;
        case (k)
            K_BEQ:  taken = rs_val == rt_val;
            K_BNE:  taken = rs_val != rt_val;
            K_BLEZ: taken = srs <= 0;
            K_BGTZ: taken = srs > 0;
            K_BLTZ: taken = srs < 0;
            K_BGEZ: taken = srs >= 0;
            default: taken = 0;
        endcase
        if (k == K_J || k == K_JAL) tgt = {p4[31:28], d_instr[25:0], 2'b00};
        if (k == K_JR || k == K_JALR) tgt = rs_val;
        if (exc_req) begin
            m_pc = EXC_VECTOR; m_src = 3; m_bd = 0;
            model_fexc();
        end else if (!stall) begin
            m_bd = jump || (k >= K_BEQ && k <= K_BGEZ);
            if (k == K_ERET) begin
                m_pc = epc; m_src = 2;
            end else if (taken || jump) begin
                m_pc = tgt; m_src = 1;
            end else begin
                m_pc = m_pc + 4; m_src = 0;
            end
            model_fexc();
        end
    endtask

    task automatic idle_inputs();
        stall = 0; exc_req = 0; epc = 0; d_valid = 0;
        d_instr = 0; d_pc = 0; rs_val = 0; rt_val = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic step();
        #1;
        @(posedge clk);
        #1;
    endtask

    // One model-checked cycle with the inputs currently applied.
    task automatic run_cycle(string tag);
        #1;
        chk({tag, ".flush"}, 32'(flush_f), 32'(exp_flush()));
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".src"}, 32'(pc_src), 32'(m_src));
        chk({tag, ".bd"}, 32'(d_bd), 32'(m_bd));
        chk({tag, ".fexc"}, 32'(f_exc), 32'(m_fexc));
        chk({tag, ".fcode"}, 32'(f_exccode), 32'(m_fcode));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st, ex;
        logic [31:0] ep;
        logic        dv;
        logic [31:0] ins, dpc, rs, rt;
        logic [31:0] e_pc;
        logic [1:0]  e_src;
        logic        e_bd, e_flush, e_fexc;
    } vec_t;

    vec_t tbl[22];

    task automatic apply_vec(int i);
        string t = $sformatf("vec%0d", i);
        bit fx;
        stall = tbl[i].st; exc_req = tbl[i].ex; epc = tbl[i].ep;
        d_valid = tbl[i].dv; d_instr = tbl[i].ins; d_pc = tbl[i].dpc;
        rs_val = tbl[i].rs; rt_val = tbl[i].rt;
        #1;
        chk({t, ".flush"}, 32'(flush_f), 32'(tbl[i].e_flush));
        @(posedge clk);
        #1;
`ifdef FETCH_ADDR_CHECK_EN
        fx = tbl[i].e_fexc;
`else
        fx = 0;
`endif
        chk({t, ".pc"}, pc, tbl[i].e_pc);
        chk({t, ".src"}, 32'(pc_src), 32'(tbl[i].e_src));
        chk({t, ".bd"}, 32'(d_bd), 32'(tbl[i].e_bd));
        chk({t, ".fexc"}, 32'(f_exc), 32'(fx));
        chk({t, ".fcode"}, 32'(f_exccode), fx ? 32'd4 : 32'd0);
    endtask

    function automatic logic [31:0] rand_instr(int k);
        logic [4:0]  rs = 5'($urandom);
        logic [4:0]  rt = 5'($urandom);
        logic [15:0] im = 16'($urandom);
        case (k)
            K_J:    return {6'd2, 26'($urandom)};
            K_JAL:  return {6'd3, 26'($urandom)};
            K_BEQ:  return {6'd4, rs, rt, im};
            K_BNE:  return {6'd5, rs, rt, im};
            K_BLEZ: return {6'd6, rs, 5'd0, im};
            K_BGTZ: return {6'd7, rs, 5'd0, im};
            K_BLTZ: return {6'd1, rs, 5'd0, im};
            K_BGEZ: return {6'd1, rs, 5'd1, im};
            K_JR:   return {6'd0, rs, 15'd0, 6'd8};
            K_JALR: return {6'd0, rs, 5'd0, 5'd31, 5'd0, 6'd9};
            K_ERET: return 32'h4200_0018;
            default: return {6'd0, rs, rt, 5'd3, 5'd0, 6'h20};
        endcase
    endfunction

    initial begin
        rst_n = 1;
        idle_inputs();
        //       st ex ep         dv ins           dpc           rs            rt            e_pc          src bd fl fx
        tbl[0]  = '{0, 0, 32'h0,    0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3004,     0, 0, 0, 0};
        tbl[1]  = '{0, 0, 32'h0,    1, 32'h1022FFFC, 32'h3010,     32'h5,        32'h5,        32'h3004,     1, 1, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,    1, 32'h14220010, 32'h3020,     32'h7,        32'h7,        32'h3004,     0, 1, 0, 0};
        tbl[3]  = '{0, 0, 32'h3040, 1, 32'h42000018, 32'h3000,     32'h0,        32'h0,        32'h3040,     2, 0, 1, 0};
        tbl[4]  = '{1, 0, 32'h3040, 1, 32'h42000018, 32'h3000,     32'h0,        32'h0,        32'h3000,     0, 0, 0, 0};
        tbl[5]  = '{1, 1, 32'h0,    1, 32'h00200008, 32'h3000,     32'h3100,     32'h0,        32'h4180,     3, 0, 1, 0};
        tbl[6]  = '{0, 0, 32'h0,    1, 32'h00200008, 32'h3000,     32'h3002,     32'h0,        32'h3002,     1, 1, 0, 1};
        tbl[7]  = '{0, 0, 32'h0,    1, 32'h00200008, 32'h3000,     32'h7000,     32'h0,        32'h7000,     1, 1, 0, 1};
        tbl[8]  = '{0, 0, 32'h0,    1, 32'h00200008, 32'h3000,     32'h3FFC,     32'h0,        32'h3FFC,     1, 1, 0, 0};
        tbl[9]  = '{0, 0, 32'h0,    1, 32'h00200009, 32'h3000,     32'h2FFC,     32'h0,        32'h2FFC,     1, 1, 0, 1};
        tbl[10] = '{0, 0, 32'h0,    1, 32'h08000C10, 32'h3000,     32'h0,        32'h0,        32'h3040,     1, 1, 0, 0};
        tbl[11] = '{0, 0, 32'h0,    1, 32'h0C000C10, 32'h5FF0,     32'h0,        32'h0,        32'h3040,     1, 1, 0, 0};
        tbl[12] = '{0, 0, 32'h0,    1, 32'h04200008, 32'h3000,     32'hFFFFFFFF, 32'h0,        32'h3024,     1, 1, 0, 0};
        tbl[13] = '{0, 0, 32'h0,    1, 32'h04210008, 32'h3000,     32'hFFFFFFFF, 32'h0,        32'h3004,     0, 1, 0, 0};
        tbl[14] = '{0, 0, 32'h0,    1, 32'h18200008, 32'h3000,     32'h0,        32'h0,        32'h3024,     1, 1, 0, 0};
        tbl[15] = '{0, 0, 32'h0,    1, 32'h1C200008, 32'h3000,     32'h0,        32'h0,        32'h3004,     0, 1, 0, 0};
        tbl[16] = '{0, 0, 32'h0,    1, 32'h1C200008, 32'h3000,     32'h1,        32'h0,        32'h3024,     1, 1, 0, 0};
        tbl[17] = '{0, 0, 32'h0,    1, 32'h10220004, 32'hFFFFFFF0, 32'h9,        32'h9,        32'h00000004, 1, 1, 0, 1};
        tbl[18] = '{0, 0, 32'h0,    0, 32'h00200008, 32'h3000,     32'h3100,     32'h0,        32'h3004,     0, 0, 0, 0};
        tbl[19] = '{0, 1, 32'h3040, 1, 32'h42000018, 32'h3000,     32'h0,        32'h0,        32'h4180,     3, 0, 1, 0};
        tbl[20] = '{0, 0, 32'h0,    1, 32'h14220010, 32'h3020,     32'h1,        32'h2,        32'h3064,     1, 1, 0, 0};
        tbl[21] = '{0, 0, 32'h0,    1, 32'h18200008, 32'h3000,     32'h80000000, 32'h0,        32'h3024,     1, 1, 0, 0};

        // Reset state, then three sequential fetches.
        do_reset();
        chk("rst.pc", pc, RESET_PC);
        chk("rst.src", 32'(pc_src), 32'd0);
        chk("rst.bd", 32'(d_bd), 32'd0);
        chk("rst.fexc", 32'(f_exc), 32'd0);
        chk("rst.fcode", 32'(f_exccode), 32'd0);
        chk("rst.flush", 32'(flush_f), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("seq%0d.pc", i), pc, RESET_PC + 32'(4 * i));
            chk($sformatf("seq%0d.src", i), 32'(pc_src), 32'd0);
        end

        for (int i = 0; i < 22; i++) begin
            do_reset();
            apply_vec(i);
        end

        // Stall holds pc, pc_src and d_bd; an exception then clears d_bd.
        do_reset();
        d_valid = 1; d_instr = 32'h00200008; rs_val = 32'h3100;
        step();
        chk("hold.pc0", pc, 32'h3100);
        chk("hold.bd0", 32'(d_bd), 32'd1);
        d_valid = 0; stall = 1;
        step();
        step();
        chk("hold.pc", pc, 32'h3100);
        chk("hold.src", 32'(pc_src), 32'd1);
        chk("hold.bd", 32'(d_bd), 32'd1);
        exc_req = 1;
        step();
        chk("hold.exc.pc", pc, EXC_VECTOR);
        chk("hold.exc.bd", 32'(d_bd), 32'd0);
        chk("hold.exc.src", 32'(pc_src), 32'd3);

        // Sequential fetch wraps past 2^32 without trapping.
        do_reset();
        d_valid = 1; d_instr = 32'h00200008; rs_val = 32'hFFFFFFFC;
        step();
        idle_inputs();
        step();
        chk("wrap.pc", pc, 32'h0);
        chk("wrap.src", 32'(pc_src), 32'd0);
`ifdef FETCH_ADDR_CHECK_EN
        chk("wrap.fexc", 32'(f_exc), 32'd1);
`else
        chk("wrap.fexc", 32'(f_exc), 32'd0);
`endif

        // Reset asserted while stalled takes effect immediately.
        d_valid = 1; d_instr = 32'h00200008; rs_val = 32'h3200;
        step();
        stall = 1; d_valid = 0;
        #1;
        rst_n = 0;
        #1;
        chk("rststall.pc", pc, RESET_PC);
        chk("rststall.bd", 32'(d_bd), 32'd0);
        chk("rststall.src", 32'(pc_src), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int k = int'($urandom_range(0, 11));
            stall   = ($urandom % 5) == 0;
            exc_req = ($urandom % 16) == 0;
            d_valid = ($urandom % 8) != 0;
            d_instr = rand_instr(k);
            d_pc    = ($urandom % 4 == 0) ? $urandom : m_pc - 32'd4;
            rt_val  = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 3));
            case ($urandom % 4)
                0: rs_val = rt_val;
                1: rs_val = 32'h0;
                2: rs_val = $urandom;
                default: rs_val = IM_BASE + 32'(4 * $urandom_range(0, 4095));
            endcase
            epc = ($urandom % 2) ? IM_BASE + 32'(4 * $urandom_range(0, 4095))
                                 : $urandom;
            run_cycle($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit: owns the PC register and selects the next fetch address. Sources, in priority order: exception vector, `eret` return, branch/jump resolved in D, sequential PC+4. Compared with the combinational next-PC logic it replaces, it adds stall handling and decode-stage flush. It also produces a registered delay-slot flag for CP0 and, optionally, fetch-address exception detection.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_4180, exception/interrupt entry address.
- `IM_BASE`, 32'h0000_3000, first legal instruction address.
- `IM_WORDS`, 4096, number of legal instruction words starting at `IM_BASE`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard stall; hold PC and `d_bd`.
- `exc_req`  in  1  CP0 exception/interrupt taken this cycle.
- `epc`  in  32  CP0 EPC value (already forwarded).
- `d_valid`  in  1  D holds a real instruction (0 = bubble).
- `d_instr`  in  32  instruction in D.
- `d_pc`  in  32  PC of the D instruction.
- `rs_val`, `rt_val`  in  32 each  forwarded GPR operands of the D instruction.
- `pc`  out  32  current fetch address.
- `flush_f`  out  1  kill the instruction currently in F.
- `d_bd`  out  1  the instruction now in D is a delay slot.
- `f_exc`  out  1  current `pc` is an illegal fetch address.
- `f_exccode`  out  5  exception code accompanying `f_exc`.
- `pc_src`  out  2  source of the current `pc`: 0 seq, 1 branch/jump, 2 eret, 3 exception.

## Operation
- **Decode from `d_instr`**:
  - `j`, `jal`: op 000010, 000011.
  - `beq`, `bne`, `blez`, `bgtz`: op 000100, 000101, 000110, 000111.
  - `bltz`, `bgez`: op 000001 with rt 00000, 00001.
  - `jr`, `jalr`: op 000000 with funct 001000, 001001.
  - `eret`: op 010000, bit25 = 1, funct 011000.
  - All decoded kinds are qualified by `d_valid`.
- **Comparisons** are signed 32-bit:
  - beq: rs==rt. bne: rs!=rt.
  - bgez: rs>=0. bgtz: rs>0. blez: rs<=0. bltz: rs<0.
- **Targets**, with p4 = `d_pc`+4:
  - branch: p4 + {sext(imm16),2'b00}, mod 2^32.
  - j/jal: {p4[31:28], instr[25:0], 2'b00}.
  - jr/jalr: `rs_val`.
  - eret: `epc`.
- **Next-PC priority**:
  1. `exc_req` → `EXC_VECTOR`.
  2. `stall` → hold.
  3. eret → `epc`.
  4. taken branch or any jump → target.
  5. otherwise → `pc`+4.
- **`flush_f`** = `exc_req` | eret (combinational). An eret has no delay slot. A branch/jump never flushes F; its delay slot is in F.
- **`d_bd`** is registered:
  - non-stalled edge: `d_bd` <= D holds a valid branch or jump (taken or not, eret excluded);
  - stall: hold;
  - `exc_req`: clear.
- **`pc_src`** updates on the same edges as `pc` and holds on stall.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - `pc` = `RESET_PC`, `pc_src` = 0, `d_bd` = 0.
  - `f_exc` = 0, `f_exccode` = 0.
  - `flush_f` follows its inputs (combinational).
- **Latency**: the PC updates one cycle after selection. A branch/jump resolved in D with its delay slot in F makes the target the next fetched address: zero penalty, no misprediction state.
- **`exc_req` with `stall`**: the exception wins and redirects.
- **eret with `stall`**: hold; no flush, no redirect.
- **eret with `exc_req`**: the vector wins.
- **Wrap-around**: PC+4 and branch targets wrap modulo 2^32 with no fault. The address check flags the result.
- **Reset mid-stall**: reset takes effect immediately; the held state is discarded.

## Configuration
- `FETCH_ADDR_CHECK_EN` defined:
  - `f_exc`/`f_exccode` are registered from the selected next PC and update with `pc`.
  - `f_exc` = 1 and `f_exccode` = 5'd4 (AdEL) when npc[1:0] != 0, or npc < `IM_BASE`, or npc >= `IM_BASE`+4·`IM_WORDS`.
  - Otherwise both are 0.
- Undefined: `f_exc` and `f_exccode` are tied to 0 and no comparator logic is generated.

## Test plan
- **Reset release** → `pc` = 0x3000, `pc_src` = 0. After 3 edges with no control flow → `pc` = 0x300C.
- **Taken beq**: `d_pc` = 0x3010, imm = 0xFFFC, rs == rt → next `pc` = 0x3004, `pc_src` = 1, `d_bd` = 1 on the following cycle, `flush_f` = 0.
- **Not-taken bne**: rs == rt at `d_pc` = 0x3020 → `pc` advances to fetch PC + 4, `d_bd` = 1.
- **eret**: `epc` = 0x3040 → `flush_f` = 1, next `pc` = 0x3040, `pc_src` = 2. Repeat with `stall` = 1 → `pc` holds, `flush_f` = 0.
- **Exception priority**: `exc_req` together with `stall` and a taken jr → `pc` = 0x4180, `pc_src` = 3, `flush_f` = 1, `d_bd` = 0.
- **Address check** (with `FETCH_ADDR_CHECK_EN`):
  - jr with `rs_val` = 0x3002 → `f_exc` = 1, `f_exccode` = 4.
  - jr with `rs_val` = 0x7000 → `f_exc` = 1, `f_exccode` = 4.
  - jr with `rs_val` = 0x3FFC → `f_exc` = 0.
  - Without the macro → `f_exc` = 0 in all three cases.
